// File: rtl/cache_assoc_ctrl.sv
// cache_assoc_ctrl: set-associative write-through cache controller with pLRU replacement and line refill.
module cache_assoc_ctrl #(
  parameter int ADDR_W     = 19,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              flush_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);
  localparam int WB  = $clog2(LINE_WORDS);
  localparam int BW  = WB > 0 ? WB : 1;
  localparam int OFF = 2 + WB;
  localparam int SB  = $clog2(SETS);
  localparam int TW  = ADDR_W - OFF - SB;
  localparam int WW  = $clog2(WAYS);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SB-1:0] fset_q, fset_d;
  logic [WW-1:0] victim_q, victim_d;
  logic refill_q, refill_d;
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0][2:0] plru_q, plru_d;
  logic [TW-1:0] tag_q [SETS][WAYS];
  logic [31:0] data_q [SETS][WAYS][LINE_WORDS];
  logic [SB-1:0] set_idx;
  logic [TW-1:0] tag_in;
  logic [BW-1:0] word, we_word;
  logic [WW-1:0] hit_way, free_way, plru_way, we_way;
  logic hit, has_free, data_we, tag_we, rd_hit;
  logic [31:0] we_data;
  // Tree pLRU bits {b2,b1,b0}; with two ways only b0 is used and holds the victim way.
  function automatic logic [2:0] plru_upd(input logic [2:0] p, input logic [WW-1:0] w);
    return (WAYS == 2) ? {p[2:1], ~w[0]} : (w[WW-1] ? {~w[0], p[1], 1'b0} : {p[2], ~w[0], 1'b1});
  endfunction
  always_comb begin
    set_idx = SB'(cpu_addr >> OFF);
    tag_in = TW'(cpu_addr >> (OFF + SB));
    word = BW'((cpu_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
    hit = 1'b0;
    hit_way = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[set_idx][w]) begin
        has_free = 1'b1;
        free_way = WW'(w);
      end
    end
    plru_way = WW'((WAYS == 2) ? {1'b0, plru_q[set_idx][0]} :
                   (plru_q[set_idx][0] ? {1'b1, plru_q[set_idx][2]} : {1'b0, plru_q[set_idx][1]}));
  end
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    fset_d = fset_q;
    victim_d = victim_q;
    refill_d = 1'b0;
    hit_cnt_d = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d = valid_q;
    plru_d = plru_q;
    data_we = 1'b0;
    tag_we = 1'b0;
    we_way = victim_q;
    we_word = beat_q;
    we_data = mem_rdata;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          fset_d = '0;
        end else if (cpu_wr) state_d = WRITE;
        else if (cpu_rd && hit) begin
          plru_d[set_idx] = plru_upd(plru_q[set_idx], hit_way);
          if (!refill_q) hit_cnt_d = hit_cnt_q + 16'(hit_cnt_q != 16'hFFFF);
        end else if (cpu_rd) begin
          miss_cnt_d = miss_cnt_q + 16'(miss_cnt_q != 16'hFFFF);
          victim_d = has_free ? free_way : plru_way;
          beat_d = '0;
          state_d = FILL;
        end
      end
      FILL: if (mem_ack) begin
        data_we = 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(LINE_WORDS - 1)) begin
          tag_we = 1'b1;
          valid_d[set_idx][victim_q] = 1'b1;
          plru_d[set_idx] = plru_upd(plru_q[set_idx], victim_q);
          refill_d = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: if (mem_ack) begin
        if (hit) begin
          data_we = 1'b1;
          we_way = hit_way;
          we_word = word;
          we_data = cpu_wdata;
          plru_d[set_idx] = plru_upd(plru_q[set_idx], hit_way);
        end
        state_d = IDLE;
      end
      FLUSH: begin
        valid_d[fset_q] = '0;
        fset_d = fset_q + 1'b1;
        if (fset_q == SB'(SETS - 1)) state_d = IDLE;
      end
    endcase
  end
  always_comb begin
    rd_hit = state_q == IDLE && !flush && !cpu_wr && cpu_rd && hit;
    cpu_ready = rd_hit || (state_q == WRITE && mem_ack);
    cpu_rdata = rd_hit ? data_q[set_idx][hit_way][word] : 32'h0;
    flush_busy = state_q == FLUSH;
    mem_req = state_q == FILL || state_q == WRITE;
    mem_we = state_q == WRITE;
    mem_addr = (state_q == FILL) ? ({cpu_addr[ADDR_W-1:OFF], {OFF{1'b0}}} | (ADDR_W'(beat_q) << 2))
                                 : {cpu_addr[ADDR_W-1:2], 2'b00};
    mem_wdata = cpu_wdata;
    hit_cnt = hit_cnt_q;
    miss_cnt = miss_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q <= '0;
      fset_q <= '0;
      victim_q <= '0;
      refill_q <= 1'b0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
      valid_q <= '0;
      plru_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      fset_q <= fset_d;
      victim_q <= victim_d;
      refill_q <= refill_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q <= valid_d;
      plru_q <= plru_d;
    end
  end
  always_ff @(posedge clk) begin
    if (data_we && !rst) data_q[set_idx][we_way][we_word] <= we_data;
    if (tag_we && !rst) tag_q[set_idx][victim_q] <= tag_in;
  end
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// tb_cache_assoc_ctrl: directed table, corner sequences and randomized traffic against a cache/memory model.
module tb_cache_assoc_ctrl;
  logic clk, rst;
  logic [18:0] cpu_addr, mem_addr;
  logic cpu_rd, cpu_wr, cpu_ready, flush, flush_busy, mem_req, mem_we, mem_ack;
  logic [31:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;
  int vectors = 0, miscompares = 0;
  logic [31:0] mem_model [int];
  logic [18:0] beats [$];
  bit m_valid [64][2];
  int m_tag [64][2];
  int m_mru [64];
  int m_hits, m_misses;
  typedef struct {
    bit wr; logic [18:0] addr; logic [31:0] wdata; int dly;
    logic [31:0] exp_rdata; int exp_lat; int exp_beats; int exp_hits; int exp_miss;
  } vec_t;
  vec_t tbl [12];

  cache_assoc_ctrl dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
    .flush_busy(flush_busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [18:0] a);
    return mem_model.exists(int'(a)) ? mem_model[int'(a)] : (32'hC0DE0000 ^ {13'h0, a});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plays the CPU and the memory for one request; returns read data and cycles before cpu_ready.
  task automatic run_req(input bit wr, input logic [18:0] a, input logic [31:0] wd, input int dly,
                         output logic [31:0] rd, output int lat);
    int waitc = 0;
    bit done = 0;
    beats.delete();
    rd = '0;
    lat = 0;
    cpu_addr = a; cpu_wdata = wd; cpu_wr = wr; cpu_rd = !wr;
    while (!done) begin
      #1;
      if (mem_req) begin
        if (waitc >= dly) begin
          mem_ack = 1;
          beats.push_back(mem_addr);
          if (mem_we) mem_model[int'(mem_addr)] = mem_wdata;
          else mem_rdata = mem_rd(mem_addr);
          waitc = 0;
        end else waitc++;
        #1;
      end
      if (cpu_ready) begin
        done = 1;
        rd = cpu_rdata;
        if (wr) check("wr_ready_is_ack", mem_ack, 1);
      end
      @(negedge clk);
      mem_ack = 0;
      if (!done) begin
        lat++;
        if (lat > 100) begin
          vectors++; miscompares++;
          $display("FAIL timeout: no cpu_ready after %0d cycles at addr %0h", lat, a);
          break;
        end
      end
    end
    cpu_rd = 0; cpu_wr = 0;
  endtask

  task automatic do_flush(output int n);
    n = 0;
    flush = 1;
    @(negedge clk);
    flush = 0;
    while (flush_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int s = 0; s < 64; s++) begin
      m_valid[s][0] = 0; m_valid[s][1] = 0; m_mru[s] = 0;
    end
    m_hits = 0; m_misses = 0;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, n, base_miss;
    cpu_addr = 0; cpu_rd = 0; cpu_wr = 0; cpu_wdata = 0; flush = 0; mem_ack = 0; mem_rdata = 0;
    mem_model[32'h008] = 32'hA; mem_model[32'h00C] = 32'hB;
    mem_model[32'h000] = 32'h100; mem_model[32'h200] = 32'h201; mem_model[32'h400] = 32'h402;
    do_reset();
    #1;
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_flush_busy", flush_busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    tbl[0]  = '{0, 19'h008, 0, 0, 32'hA, 3, 2, 0, 1};
    tbl[1]  = '{0, 19'h00C, 0, 0, 32'hB, 0, 0, 1, 1};
    tbl[2]  = '{0, 19'h000, 0, 1, 32'h100, 5, 2, 1, 2};
    tbl[3]  = '{0, 19'h200, 0, 0, 32'h201, 3, 2, 1, 3};
    tbl[4]  = '{0, 19'h000, 0, 0, 32'h100, 0, 0, 2, 3};
    tbl[5]  = '{0, 19'h400, 0, 2, 32'h402, 7, 2, 2, 4};
    tbl[6]  = '{0, 19'h000, 0, 0, 32'h100, 0, 0, 3, 4};
    tbl[7]  = '{0, 19'h200, 0, 0, 32'h201, 3, 2, 3, 5};
    tbl[8]  = '{1, 19'h008, 32'h55, 3, 0, 4, 1, 3, 5};
    tbl[9]  = '{0, 19'h008, 0, 0, 32'h55, 0, 0, 4, 5};
    tbl[10] = '{1, 19'h600, 32'h77, 0, 0, 1, 1, 4, 5};
    tbl[11] = '{0, 19'h600, 0, 0, 32'h77, 3, 2, 4, 6};
    for (int i = 0; i < 12; i++) begin
      run_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].dly, rd, lat);
      if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      check($sformatf("tbl%0d_beats", i), beats.size(), tbl[i].exp_beats);
      if (beats.size() == 2 && tbl[i].exp_beats == 2)
        for (int b = 0; b < 2; b++)
          check($sformatf("tbl%0d_beat%0d_addr", i, b), beats[b], (tbl[i].addr & ~19'h7) + 19'(4 * b));
      if (beats.size() == 1 && tbl[i].exp_beats == 1)
        check($sformatf("tbl%0d_wr_addr", i), beats[0], tbl[i].addr & ~19'h3);
      check($sformatf("tbl%0d_hit_cnt", i), hit_cnt, tbl[i].exp_hits);
      check($sformatf("tbl%0d_miss_cnt", i), miss_cnt, tbl[i].exp_miss);
    end
    run_req(0, 19'h010, 0, 0, rd, lat);
    do_flush(n);
    check("flush_busy_cycles", n, 64);
    foreach (tbl[i]) if (i < 3) begin
      base_miss = miss_cnt;
      run_req(0, (i == 0) ? 19'h008 : (i == 1) ? 19'h000 : 19'h010, 0, 0, rd, lat);
      check($sformatf("post_flush%0d_latency", i), lat, 3);
      check($sformatf("post_flush%0d_miss_cnt", i), miss_cnt, base_miss + 1);
    end
    do_reset();
    cpu_rd = 1; cpu_addr = 19'h1000;
    @(negedge clk); #1;
    check("fill_beat0_addr", mem_addr, 19'h1000);
    mem_ack = 1; mem_rdata = mem_rd(19'h1000);
    @(negedge clk); mem_ack = 0; #1;
    check("fill_beat1_req", mem_req, 1);
    check("fill_beat1_addr", mem_addr, 19'h1004);
    rst = 1;
    @(negedge clk); #1;
    check("rst_mid_fill_mem_req", mem_req, 0);
    check("rst_mid_fill_miss_cnt", miss_cnt, 0);
    rst = 0; cpu_rd = 0;
    @(negedge clk);
    run_req(0, 19'h1000, 0, 0, rd, lat);
    check("refetch_rdata", rd, mem_rd(19'h1000));
    check("refetch_beats", beats.size(), 2);
    check("refetch_miss_cnt", miss_cnt, 1);
    check("refetch_hit_cnt", hit_cnt, 0);
    do_reset();
    for (int k = 0; k < 150; k++) begin
      int r, s, t, dly, way, vic, elat;
      logic [18:0] a;
      logic [31:0] erd;
      bit wr;
      r = $urandom_range(0, 24);
      if (r == 0) begin
        do_flush(n);
        check($sformatf("rnd%0d_flush_cycles", k), n, 64);
        for (int q = 0; q < 64; q++) begin m_valid[q][0] = 0; m_valid[q][1] = 0; end
        continue;
      end
      wr = r < 7;
      s = $urandom_range(0, 3); t = $urandom_range(0, 3); dly = $urandom_range(0, 2);
      a = 19'((t << 9) | (s << 3) | ($urandom_range(0, 1) << 2));
      way = -1;
      for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
      erd = mem_rd(a);
      if (wr) begin
        if (way >= 0) m_mru[s] = way;
        elat = dly + 1;
      end else if (way >= 0) begin
        m_hits++; m_mru[s] = way; elat = 0;
      end else begin
        m_misses++;
        vic = !m_valid[s][0] ? 0 : !m_valid[s][1] ? 1 : 1 - m_mru[s];
        m_valid[s][vic] = 1; m_tag[s][vic] = t; m_mru[s] = vic;
        elat = 1 + 2 * (dly + 1);
      end
      run_req(wr, a, $urandom, dly, rd, lat);
      if (!wr) check($sformatf("rnd%0d_rdata", k), rd, erd);
      check($sformatf("rnd%0d_latency", k), lat, elat);
      check($sformatf("rnd%0d_hit_cnt", k), hit_cnt, m_hits);
      check($sformatf("rnd%0d_miss_cnt", k), miss_cnt, m_misses);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_assoc_ctrl.md
CACHE_ASSOC_CTRL -- requirements
Module: cache_assoc_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-002 Parameter ADDR_W, default 19, SHALL set the CPU/memory byte-address width.
REQ-003 Parameter SETS, default 64, SHALL set the set count (power of two, 2..256).
REQ-004 Parameter WAYS, default 2, SHALL set associativity (legal values 2 or 4).
REQ-005 Parameter LINE_WORDS, default 2, SHALL set 32-bit words per line (power of two, 1..8).
REQ-006 Address fields SHALL be: word = addr[OFF-1:2] with OFF = 2+log2(LINE_WORDS); set = next log2(SETS) bits; tag = remaining upper bits.
REQ-007 Ports SHALL be:
 clk  in  1  clock
 rst  in  1  sync active-high reset
 cpu_addr  in  ADDR_W  byte address
 cpu_rd  in  1  read request, held until cpu_ready
 cpu_wr  in  1  write request, held until cpu_ready
 cpu_wdata  in  32  write data
 cpu_rdata  out  32  read data, valid when cpu_ready and read
 cpu_ready  out  1  request complete this cycle
 flush  in  1  invalidate-all request
 flush_busy  out  1  flush in progress
 mem_req  out  1  memory request, held until mem_ack
 mem_we  out  1  1 = memory write, 0 = memory read
 mem_addr  out  ADDR_W  memory word address (byte, bits[1:0]=0)
 mem_wdata  out  32  memory write data
 mem_rdata  in  32  memory read data, valid with mem_ack
 mem_ack  in  1  one beat complete
 hit_cnt  out  16  read-hit count, saturating
 miss_cnt  out  16  read-miss count, saturating

Function
REQ-008 FSM states SHALL be IDLE, FILL, WRITE, FLUSH.
REQ-009 IDLE priority SHALL be flush > cpu_wr > cpu_rd; cpu_rd and cpu_wr both high is treated as a write.
REQ-010 Read hit in IDLE: cpu_ready=1 and cpu_rdata = hit-way word, combinationally, same cycle; pLRU update at that edge.
REQ-011 Read miss in IDLE: cpu_ready=0; miss_cnt+1; victim latched; go FILL next edge.
REQ-012 Victim: lowest-index invalid way in the set; if all ways are valid, the pLRU victim.
REQ-013 FILL: mem_req=1, mem_we=0, mem_addr = line base + 4*beat; beat counter starts at 0; each mem_ack writes mem_rdata into victim word [beat], beat+1.
REQ-014 At the last-beat ack, victim tag is written, valid=1, pLRU updated, and the FSM goes to IDLE; the retried read then hits and SHALL NOT increment hit_cnt (one-cycle refill flag).
REQ-015 Write (write-through, no-write-allocate): IDLE -> WRITE; mem_req=1, mem_we=1, mem_addr = cpu_addr with bits[1:0] cleared, mem_wdata = cpu_wdata.
REQ-016 In WRITE, cpu_ready SHALL equal mem_ack; at the ack edge a hitting way's word is updated and pLRU updated; a miss leaves the cache unchanged; then go IDLE.
REQ-017 pLRU WAYS=2: one bit per set = victim way; access way w sets it to ~w.
REQ-018 pLRU WAYS=4: bits b0,b1,b2 per set; victim = b0 ? (b2 ? 3 : 2) : (b1 ? 1 : 0); access 0 -> b0=1,b1=1; 1 -> b0=1,b1=0; 2 -> b0=0,b2=1; 3 -> b0=0,b2=0; other bits are unchanged.
REQ-019 FLUSH: set counter from 0 clears valid of all ways of one set per cycle; after set SETS-1, go IDLE (SETS cycles total); flush_busy=1 throughout; cpu_ready=0.
REQ-020 flush asserted in FILL or WRITE SHALL be ignored until IDLE; the requester holds it.
REQ-021 Counters SHALL saturate at 16'hFFFF and not wrap.
REQ-022 Outside FILL/WRITE, mem_req=0 and mem_we=0.
REQ-023 cpu_rdata SHALL be 0 when no read hit.

Reset
REQ-024 rst SHALL, at the next edge and from any state (including mid-FILL or mid-FLUSH), set state IDLE, clear all valid and pLRU bits, clear beat/set counters, refill flag and both counters; mem_req drops that edge.
REQ-025 Data and tag arrays need not be reset.
REQ-026 After reset: cpu_ready=0, flush_busy=0, mem_req=0, hit_cnt=0, miss_cnt=0.

Verification
REQ-027 Cold read 0x00008 -> FILL beats at mem_addr 0x00008 and 0x0000C, data 0xA,0xB; next cycle cpu_ready with rdata=0xA; miss_cnt=1, hit_cnt=0.
REQ-028 Repeat read of 0x0000C -> same-cycle cpu_ready, rdata=0xB, hit_cnt=1.
REQ-029 Read tags 0,1 then tag 0 again, then tag 2 in set 0 (WAYS=2) -> tag 1 evicted; a read of tag 1 misses, a read of tag 0 hits.
REQ-030 Write 0x55 to a hitting address with mem_ack delayed 3 cycles -> cpu_ready coincides with ack; a following read returns 0x55; write miss -> no fill, miss_cnt unchanged.
REQ-031 flush after filling 3 sets -> flush_busy for exactly 64 cycles; all later reads miss.
REQ-032 rst during FILL beat 1 -> mem_req=0 next cycle; the same read afterwards misses and refills both beats.
